// File: rtl/vline_tap_gen.sv
// vline_tap_gen: two-line buffer producing 3-tap vertical pixel columns for the vertical filter
module vline_tap_gen #(
  parameter int Y_DEPTH  = 8,
  parameter int H_ACTIVE = 640,
  parameter int ADDR_W   = 10
) (
  input  logic               r_arst,
  input  logic               r_pclk,
  input  logic               i_vsync,
  input  logic               i_valid,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic               o_valid,
  output logic               o_sol,
  output logic [Y_DEPTH-1:0] o_pixel_11_11,
  output logic [Y_DEPTH-1:0] o_pixel_00_11,
  output logic [Y_DEPTH-1:0] o_pixel_01_11
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE - 1);
  logic [Y_DEPTH-1:0] lb0 [2**ADDR_W];
  logic [Y_DEPTH-1:0] lb1 [2**ADDR_W];
  logic [ADDR_W-1:0]  col_cnt;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         row_cnt;
  logic [1:0]         row_base;
  logic               tap_ok;
  // vsync restarts the frame in the same cycle, so a coincident beat lands at column 0 of row 0
  assign addr     = i_vsync ? '0 : col_cnt;
  assign row_base = i_vsync ? 2'd0 : row_cnt;
  assign tap_ok   = i_valid && row_base == 2'd2;
  // line buffers: read-before-write shifts line y into LB1 as line y+1 enters LB0
  always_ff @(posedge r_pclk) begin
    if (i_valid) begin
      lb0[addr] <= i_pixel;
      lb1[addr] <= lb0[addr];
    end
  end
  // raster position; row count saturates once two complete lines are stored
  always_ff @(posedge r_pclk or posedge r_arst) begin
    if (r_arst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (i_valid) begin
      col_cnt <= addr == LAST ? '0 : addr + 1'b1;
      row_cnt <= (addr == LAST && row_base != 2'd2) ? row_base + 2'd1 : row_base;
    end else if (i_vsync) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end
  // registered taps one cycle after the accepted beat; pixels hold across gaps
  always_ff @(posedge r_pclk or posedge r_arst) begin
    if (r_arst) begin
      o_valid       <= 1'b0;
      o_sol         <= 1'b0;
      o_pixel_11_11 <= '0;
      o_pixel_00_11 <= '0;
      o_pixel_01_11 <= '0;
    end else begin
      o_valid <= tap_ok;
      o_sol   <= tap_ok && addr == '0;
      if (i_valid) begin
        o_pixel_11_11 <= lb1[addr];
        o_pixel_00_11 <= lb0[addr];
        o_pixel_01_11 <= i_pixel;
      end
    end
  end
endmodule

// File: tb/tb_vline_tap_gen.sv
// tb_vline_tap_gen: scoreboard bench for the 3-tap vertical line generator
module tb_vline_tap_gen;
  logic       r_arst = 1'b1;
  logic       r_pclk = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_pixel = '0;
  logic       o_valid, o_sol;
  logic [7:0] o_pixel_11_11, o_pixel_00_11, o_pixel_01_11;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    int         cyc;
    logic       sol;
    logic [7:0] p11;
    logic [7:0] p00;
    logic [7:0] p01;
  } exp_t;
  exp_t q[$];

  vline_tap_gen #(.Y_DEPTH(8), .H_ACTIVE(4), .ADDR_W(2)) dut (
    .r_arst(r_arst), .r_pclk(r_pclk), .i_vsync(i_vsync), .i_valid(i_valid),
    .i_pixel(i_pixel), .o_valid(o_valid), .o_sol(o_sol),
    .o_pixel_11_11(o_pixel_11_11), .o_pixel_00_11(o_pixel_00_11),
    .o_pixel_01_11(o_pixel_01_11)
  );

  always #5 r_pclk = ~r_pclk;
  always @(posedge r_pclk) cyc <= cyc + 1;

  function automatic void chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, req);
    end
  endfunction

  task automatic send(input int pix, input bit vs, input bit ev, input int p11, input int p00, input bit sol);
    @(posedge r_pclk);
    #1;
    i_vsync = vs;
    i_valid = 1'b1;
    i_pixel = 8'(pix);
    if (ev) q.push_back('{cyc + 1, sol, 8'(p11), 8'(p00), 8'(pix)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge r_pclk);
      #1;
      i_vsync = 1'b0;
      i_valid = 1'b0;
    end
  endtask

  task automatic vsync();
    @(posedge r_pclk);
    #1;
    i_vsync = 1'b1;
    i_valid = 1'b0;
  endtask

  task automatic outs_zero(input string n);
    chk({n, "_valid"}, o_valid, 0);
    chk({n, "_sol"}, o_sol, 0);
    chk({n, "_p11"}, o_pixel_11_11, 0);
    chk({n, "_p00"}, o_pixel_00_11, 0);
    chk({n, "_p01"}, o_pixel_01_11, 0);
  endtask

  // rows 0..2 of the base stream; taps on row 2 are (10+i, 20+i, 30+i)
  task automatic base_frame();
    for (int i = 0; i < 4; i++) send(10 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(20 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(30 + i, 0, 1, 10 + i, 20 + i, i == 0);
  endtask

  // monitor: every cycle either a due expectation is matched or o_valid must be low
  always @(negedge r_pclk) begin
    if (!r_arst) begin
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("tap_valid", o_valid, 1);
        chk("tap_sol", o_sol, int'(e.sol));
        chk("tap_p11", o_pixel_11_11, e.p11);
        chk("tap_p00", o_pixel_00_11, e.p00);
        chk("tap_p01", o_pixel_01_11, e.p01);
      end else begin
        chk("no_spurious_valid", o_valid, 0);
      end
    end
  end

  initial begin
    int budget;
    // 1: reset held two clocks, then idle
    repeat (2) @(negedge r_pclk);
    outs_zero("reset");
    #1 r_arst = 1'b0;
    idle(3);
    @(negedge r_pclk);
    outs_zero("idle_after_reset");
    // 2 and 3: continuous frame, then row 3 proves the line shift
    vsync();
    base_frame();
    for (int i = 0; i < 4; i++) send(40 + i, 0, 1, 20 + i, 30 + i, i == 0);
    idle(2);
    // 4: same stream with gaps; pixels must hold through the gap
    vsync();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        send(10 * (r + 1) + i, 0, r == 2, 10 + i, 20 + i, i == 0);
        idle(1);
        @(negedge r_pclk);
        @(negedge r_pclk);
        chk("hold_p01", o_pixel_01_11, 10 * (r + 1) + i);
        if (r == 2) chk("hold_p11", o_pixel_11_11, 10 + i);
      end
    end
    // 5: vsync after two beats of row 2, new frame must not leak stale lines
    vsync();
    for (int i = 0; i < 4; i++) send(10 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(20 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) send(30 + i, 0, 1, 10 + i, 20 + i, i == 0);
    vsync();
    for (int i = 0; i < 4; i++) send(50 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(60 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(70 + i, 0, 1, 50 + i, 60 + i, i == 0);
    idle(2);
    // 6: vsync coincident with first pixel; 99 is column 0 and 100..102 follow
    send(99, 1, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) send(99 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(110 + i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(120 + i, 0, 1, 99 + i, 110 + i, i == 0);
    for (int i = 0; i < 2; i++) send(130 + i, 0, 1, 110 + i, 120 + i, i == 0);
    idle(1);
    @(negedge r_pclk);
    @(negedge r_pclk);
    #2 r_arst = 1'b1;
    #1 outs_zero("async_reset");
    @(negedge r_pclk);
    #1 r_arst = 1'b0;
    base_frame();
    idle(1);
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(negedge r_pclk);
      budget--;
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
